ddr3_rd_master: RTL and testbench

DDR3_RD_MASTER -- requirements
Module: ddr3_rd_master

---
 rtl/ddr3_rd_master.sv | 167 ++++++++++++++++
 tb/tb_ddr3_rd_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rd_master.sv
// rtl/ddr3_rd_master.sv - AXI read master: splits a word-count command into 4 KB-safe bursts streamed into a FIFO
module ddr3_rd_master #(
  parameter int MAX_BURST = 16
) (
  input  logic        USER_CLK,
  input  logic        USER_RST_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [29:0] CMD_ADDR,
  input  logic [15:0] CMD_LEN,
  output logic        DONE,
  output logic        ERR,
  output logic [29:0] M00_AXI_ARADDR,
  output logic [7:0]  M00_AXI_ARLEN,
  output logic        M00_AXI_ARVALID,
  input  logic        M00_AXI_ARREADY,
  input  logic [31:0] M00_AXI_RDATA,
  input  logic [1:0]  M00_AXI_RRESP,
  input  logic        M00_AXI_RLAST,
  input  logic        M00_AXI_RVALID,
  output logic        M00_AXI_RREADY,
  output logic [31:0] FIFO_DIN,
  output logic        FIFO_WRITE,
  input  logic        FIFO_FULL_N
);

  localparam logic [15:0] MAX_B = 16'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;       // start byte address of the current/next burst
  logic [15:0] remain_q, remain_d;   // words of the command not yet received
  logic [8:0]  beat_q, beat_d;       // beats left in the outstanding burst
  logic [7:0]  arlen_q, arlen_d;
  logic        err_q, err_d;         // sticky error for the running command
  logic        done_q, done_d;
  logic        err_out_q, err_out_d;

  logic        beat_fire;
  logic        last_beat;
  logic [8:0]  burst_words;
  logic [29:0] next_addr;
  logic        unused_cmd_lsb;

  // The word address is always aligned; the byte offset of the command is discarded.
  assign unused_cmd_lsb = ^CMD_ADDR[1:0];

  // ARLEN for a burst starting at word offset word_off within its 4 KB page,
  // limited by the words still owed and by the burst ceiling.
  function automatic logic [7:0] burst_arlen(input logic [9:0] word_off,
                                             input logic [15:0] remain);
    logic [15:0] b;
    logic [15:0] to_page;
    to_page = 16'd1024 - {6'd0, word_off};
    b = remain;
    if (to_page < b) b = to_page;
    if (MAX_B < b) b = MAX_B;
    return 8'(b - 16'd1);
  endfunction

  assign beat_fire   = (state_q == S_DATA) && M00_AXI_RVALID && FIFO_FULL_N;
  assign last_beat   = (beat_q == 9'd1);
  assign burst_words = {1'b0, arlen_q} + 9'd1;
  assign next_addr   = addr_q + {19'd0, burst_words, 2'b00};

  // State and datapath registers
  always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
    if (!USER_RST_N) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      beat_q    <= '0;
      arlen_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      beat_q    <= beat_d;
      arlen_q   <= arlen_d;
      err_q     <= err_d;
      done_q    <= done_d;
      err_out_q <= err_out_d;
    end
  end

  // Next-state and counter updates
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    beat_d    = beat_q;
    arlen_d   = arlen_q;
    err_d     = err_q;
    done_d    = 1'b0;
    err_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          addr_d   = {CMD_ADDR[29:2], 2'b00};
          remain_d = CMD_LEN;
          if (CMD_LEN == 16'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ADDR;
            arlen_d = burst_arlen(CMD_ADDR[11:2], CMD_LEN);
          end
        end
      end
      S_ADDR: begin
        if (M00_AXI_ARREADY) begin
          state_d = S_DATA;
          beat_d  = burst_words;
        end
      end
      S_DATA: begin
        if (beat_fire) begin
          beat_d   = beat_q - 9'd1;
          remain_d = remain_q - 16'd1;
          // A bad response or an RLAST that disagrees with our own beat count
          // flags the command; the burst still ends on the counted beat.
          if ((M00_AXI_RRESP != 2'b00) || (M00_AXI_RLAST != last_beat)) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            addr_d = next_addr;
            if (remain_q == 16'd1) begin
              state_d = S_FIN;
            end else begin
              state_d = S_ADDR;
              arlen_d = burst_arlen(next_addr[11:2], remain_q - 16'd1);
            end
          end
        end
      end
      S_FIN: begin
        done_d    = 1'b1;
        err_out_d = err_q;
        err_d     = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and stream outputs; data passes straight through to the FIFO
  always_comb begin
    CMD_READY       = (state_q == S_IDLE);
    M00_AXI_ARVALID = (state_q == S_ADDR);
    M00_AXI_ARADDR  = addr_q;
    M00_AXI_ARLEN   = arlen_q;
    M00_AXI_RREADY  = (state_q == S_DATA) && FIFO_FULL_N;
    FIFO_WRITE      = M00_AXI_RREADY && M00_AXI_RVALID;
    FIFO_DIN        = M00_AXI_RDATA;
    DONE            = done_q;
    ERR             = err_out_q;
  end

endmodule

// File: tb/tb_ddr3_rd_master.sv
// tb/tb_ddr3_rd_master.sv - directed self-checking bench for ddr3_rd_master
module tb_ddr3_rd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [29:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        done;
  logic        err;
  logic [29:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] fifo_din;
  logic        fifo_write;
  logic        fifo_full_n = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [29:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  logic [31:0] fifo_log[$];
  int          done_cnt = 0;
  logic        last_err = 1'b0;

  logic [29:0] sl_addr = '0;
  int          sl_left = 0;
  logic        sl_active = 1'b0;
  int          cmd_beat = 0;
  int          resp_err_idx = -1;
  logic        rlast_bad = 1'b0;

  always #5 clk = ~clk;

  ddr3_rd_master #(.MAX_BURST(16)) dut (
    .USER_CLK        (clk),
    .USER_RST_N      (rst_n),
    .CMD_VALID       (cmd_valid),
    .CMD_READY       (cmd_ready),
    .CMD_ADDR        (cmd_addr),
    .CMD_LEN         (cmd_len),
    .DONE            (done),
    .ERR             (err),
    .M00_AXI_ARADDR  (araddr),
    .M00_AXI_ARLEN   (arlen),
    .M00_AXI_ARVALID (arvalid),
    .M00_AXI_ARREADY (arready),
    .M00_AXI_RDATA   (rdata),
    .M00_AXI_RRESP   (rresp),
    .M00_AXI_RLAST   (rlast),
    .M00_AXI_RVALID  (rvalid),
    .M00_AXI_RREADY  (rready),
    .FIFO_DIN        (fifo_din),
    .FIFO_WRITE      (fifo_write),
    .FIFO_FULL_N     (fifo_full_n)
  );

  // Records handshakes at the clock edge where they take effect.
  always @(posedge clk) begin
    if (!rst_n) begin
      sl_active = 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_addr_log.push_back(araddr);
        ar_len_log.push_back(arlen);
        sl_addr   = araddr;
        sl_left   = int'(arlen) + 1;
        sl_active = 1'b1;
      end
      if (rvalid && rready) begin
        sl_addr = sl_addr + 30'd4;
        sl_left = sl_left - 1;
        cmd_beat = cmd_beat + 1;
        if (sl_left == 0) sl_active = 1'b0;
      end
      if (fifo_write) fifo_log.push_back(fifo_din);
      if (done) begin
        done_cnt = done_cnt + 1;
        last_err = err;
      end
    end
  end

  // Read-data slave: each word carries its own byte address.
  always @(negedge clk) begin
    rvalid = sl_active;
    rdata  = {2'b00, sl_addr};
    rlast  = (sl_left == 1) ^ rlast_bad;
    rresp  = (cmd_beat == resp_err_idx) ? 2'b10 : 2'b00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [29:0] a, input logic [15:0] n);
    @(negedge clk);
    ar_addr_log.delete();
    ar_len_log.delete();
    fifo_log.delete();
    cmd_beat  = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    #1 check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 30'h155;
    cmd_len   = 16'd7;
    #1 check("arvalid_after_accept", 32'(arvalid), 32'(n != 16'd0));
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt - start), 32'd1);
    #1 check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic wait_words(input int want, input int budget);
    int n;
    n = 0;
    while (fifo_log.size() < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("words_reached", 32'(fifo_log.size() >= want), 32'd1);
  endtask

  task automatic check_ar(input int idx, input logic [29:0] a, input logic [7:0] l);
    if (idx < ar_addr_log.size()) begin
      check("ar_addr", {2'b00, ar_addr_log[idx]}, {2'b00, a});
      check("ar_len", 32'(ar_len_log[idx]), 32'(l));
    end else begin
      check("ar_missing", 32'(ar_addr_log.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_stream(input logic [29:0] start, input int n);
    check("fifo_count", 32'(fifo_log.size()), 32'(n));
    for (int i = 0; i < n && i < fifo_log.size(); i++) begin
      logic [29:0] a;
      a = start + 30'(4 * i);
      check("fifo_word", fifo_log[i], {2'b00, a});
    end
  endtask

  initial begin
    int n0;
    int dc;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_araddr", {2'b00, araddr}, 32'd0);
    check("rst_arlen", 32'(arlen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("ready_after_release", 32'(cmd_ready), 32'd1);

    // 20 words from 0x100: 16 + 4
    send_cmd(30'h100, 16'd20);
    wait_done(200);
    check("ar_count_a", 32'(ar_addr_log.size()), 32'd2);
    check_ar(0, 30'h100, 8'd15);
    check_ar(1, 30'h140, 8'd3);
    check_stream(30'h100, 20);
    check("err_a", 32'(last_err), 32'd0);

    // Page-boundary split: 2 words before 0x1000, 6 after
    send_cmd(30'hFF8, 16'd8);
    wait_done(200);
    check("ar_count_b", 32'(ar_addr_log.size()), 32'd2);
    check_ar(0, 30'hFF8, 8'd1);
    check_ar(1, 30'h1000, 8'd5);
    check_stream(30'hFF8, 8);
    check("err_b", 32'(last_err), 32'd0);

    // FIFO back-pressure for 5 cycles mid-burst
    send_cmd(30'h2000, 16'd16);
    wait_words(4, 100);
    n0 = fifo_log.size();
    fifo_full_n = 1'b0;
    repeat (5) begin
      #1;
      check("stall_rready", 32'(rready), 32'd0);
      check("stall_fifo_write", 32'(fifo_write), 32'd0);
      @(negedge clk);
    end
    check("stall_no_words", 32'(fifo_log.size()), 32'(n0));
    fifo_full_n = 1'b1;
    wait_done(200);
    check_stream(30'h2000, 16);
    check("err_c", 32'(last_err), 32'd0);

    // SLVERR on the third beat; data still delivered
    resp_err_idx = 2;
    send_cmd(30'h3000, 16'd8);
    wait_done(200);
    resp_err_idx = -1;
    check_stream(30'h3000, 8);
    check("err_slverr", 32'(last_err), 32'd1);

    // Following clean command reports no error
    send_cmd(30'h3100, 16'd4);
    wait_done(200);
    check_stream(30'h3100, 4);
    check("err_clean_after", 32'(last_err), 32'd0);

    // RLAST early on beats 1-3 and missing on beat 4
    rlast_bad = 1'b1;
    send_cmd(30'h3200, 16'd4);
    wait_done(200);
    rlast_bad = 1'b0;
    check_stream(30'h3200, 4);
    check("err_rlast", 32'(last_err), 32'd1);

    // Zero length: no AR, DONE two cycles after accept
    send_cmd(30'h400, 16'd0);
    check("len0_done_early", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    check("len0_done", 32'(done), 32'd1);
    check("len0_err", 32'(err), 32'd0);
    @(negedge clk);
    #1 check("len0_done_drop", 32'(done), 32'd0);
    check("len0_no_ar", 32'(ar_addr_log.size()), 32'd0);

    // Address wrap at the top of the 30-bit space
    send_cmd(30'h3FFFFFC0, 16'd32);
    wait_done(300);
    check("ar_count_wrap", 32'(ar_addr_log.size()), 32'd2);
    check_ar(0, 30'h3FFFFFC0, 8'd15);
    check_ar(1, 30'h0, 8'd15);
    check_stream(30'h3FFFFFC0, 32);
    check("err_wrap", 32'(last_err), 32'd0);

    // Reset while beat 5 is presented
    send_cmd(30'h4000, 16'd16);
    wait_words(4, 100);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rready", 32'(rready), 32'd0);
    check("mid_rst_fifo_write", 32'(fifo_write), 32'd0);
    check("mid_rst_arvalid", 32'(arvalid), 32'd0);
    check("mid_rst_araddr", {2'b00, araddr}, 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt), 32'(dc));
    #1 check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    send_cmd(30'h5000, 16'd4);
    wait_done(200);
    check_ar(0, 30'h5000, 8'd3);
    check_stream(30'h5000, 4);
    check("err_after_rst", 32'(last_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
